// File: rtl/seq11_pattern_tx_if.sv
// Request/stream bundle between a frame requester and the "11" pattern transmitter.
// The master drives the frame request; the slave (transmitter) drives the stream and status.
interface seq11_pattern_tx_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 3
);
   logic             start;
   logic [WIDTH-1:0] pat;
   logic [LEN_W-1:0] len;
   logic             x;
   logic             x_valid;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] exp_cnt;

   modport master (output start, pat, len, input x, x_valid, busy, done, exp_cnt);
   modport slave  (input start, pat, len, output x, x_valid, busy, done, exp_cnt);
endinterface

// File: rtl/seq11_pattern_tx.sv
// Serial pattern transmitter feeding the "11" detector, LSB first, one bit per clock.
// Alongside the stream it keeps the golden count of overlapping "11" pairs sent in the frame.
module seq11_pattern_tx #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 3
) (
   input logic             clk,
   input logic             rst_b,
   seq11_pattern_tx_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [LEN_W-1:0] bits_left;
   logic             prev;
   logic             x_q;
   logic             x_valid_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] exp_cnt_q;
   logic [LEN_W-1:0] eff_len;

   always_comb begin
      eff_len = bus.len;
      if (bus.len > LEN_MAX) eff_len = LEN_MAX;
   end

   // The first bit is loaded onto x at the accepting edge so it appears one cycle
   // after start; bits_left counts the bits still waiting behind the one on x.
   // Each bit is scored against prev at the edge that ends its cycle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         shift_reg <= '0;
         bits_left <= '0;
         prev      <= 1'b0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         exp_cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               x_q       <= 1'b0;
               x_valid_q <= 1'b0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
               if (bus.start) begin
                  exp_cnt_q <= '0;
                  prev      <= 1'b0;
                  shift_reg <= bus.pat >> 1;
                  if (eff_len == '0) begin
                     state     <= DONE;
                     done_q    <= 1'b1;
                     bits_left <= '0;
                  end else begin
                     state     <= SHIFT;
                     x_q       <= bus.pat[0];
                     x_valid_q <= 1'b1;
                     busy_q    <= 1'b1;
                     bits_left <= eff_len - 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (x_q && prev && (exp_cnt_q != CNT_MAX)) exp_cnt_q <= exp_cnt_q + 1'b1;
               prev <= x_q;
               if (bits_left == '0) begin
                  state     <= DONE;
                  x_q       <= 1'b0;
                  x_valid_q <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end else begin
                  x_q       <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  bits_left <= bits_left - 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               x_q       <= 1'b0;
               x_valid_q <= 1'b0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.x       = x_q;
   assign bus.x_valid = x_valid_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.exp_cnt = exp_cnt_q;
endmodule

// File: tb/tb_seq11_pattern_tx.sv
// Self-checking bench for seq11_pattern_tx: vector table, hand-written corner
// sequences and random frames scored against a bit-list model of the frame.
module tb_seq11_pattern_tx;
   localparam int WIDTH = 8;
   localparam int LEN_W = 4;
   localparam int CNT_W = 3;

   typedef struct {
      logic [WIDTH-1:0] pat;
      int               len;
      int               exp_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_b;
   int   n_checks = 0;
   int   n_fail = 0;
   vec_t vecs[12];

   always #5 clk = ~clk;

   seq11_pattern_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

   seq11_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Frame model: the clamped bit list is pat[0..eff-1]; count adjacent 1-1 pairs.
   function automatic int eff_of(input int l);
      return (l > WIDTH) ? WIDTH : l;
   endfunction

   function automatic int model_pairs(input logic [WIDTH-1:0] p, input int l);
      int eff = eff_of(l);
      int cnt = 0;
      for (int i = 1; i < eff; i++)
         if (p[i] && p[i-1]) cnt++;
      if (cnt > (1 << CNT_W) - 1) cnt = (1 << CNT_W) - 1;
      return cnt;
   endfunction

   // Entered #1 after the accepting edge; leaves #1 into the DONE cycle.
   task automatic check_frame_body(input logic [WIDTH-1:0] p, input int l, input int exp_cnt,
                                   input bit poke_start, input string tag);
      int eff = eff_of(l);
      for (int i = 0; i < eff; i++) begin
         check_output({tag, " x"}, 32'(bus.x), 32'(p[i]));
         check_output({tag, " x_valid"}, 32'(bus.x_valid), 32'd1);
         check_output({tag, " busy"}, 32'(bus.busy), 32'd1);
         check_output({tag, " done early"}, 32'(bus.done), 32'd0);
         if (poke_start) bus.start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      check_output({tag, " done"}, 32'(bus.done), 32'd1);
      check_output({tag, " x_valid in done"}, 32'(bus.x_valid), 32'd0);
      check_output({tag, " busy in done"}, 32'(bus.busy), 32'd0);
      check_output({tag, " x in done"}, 32'(bus.x), 32'd0);
      check_output({tag, " exp_cnt"}, 32'(bus.exp_cnt), 32'(exp_cnt));
      if (poke_start) bus.start = 1'($urandom_range(0, 1));
   endtask

   task automatic apply_stimulus(input logic [WIDTH-1:0] p, input int l, input int exp_cnt,
                                 input bit poke_start, input string tag);
      @(negedge clk);
      bus.start = 1'b1;
      bus.pat   = p;
      bus.len   = LEN_W'(l);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.pat   = WIDTH'($urandom);
      bus.len   = LEN_W'($urandom);
      check_frame_body(p, l, exp_cnt, poke_start, tag);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_output({tag, " idle x_valid"}, 32'(bus.x_valid), 32'd0);
      check_output({tag, " idle busy"}, 32'(bus.busy), 32'd0);
      check_output({tag, " idle done"}, 32'(bus.done), 32'd0);
      check_output({tag, " exp_cnt held"}, 32'(bus.exp_cnt), 32'(exp_cnt));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] cur_p, nxt_p, rp;
      int               cur_l, nxt_l, rl;

      vecs[0]  = '{8'b0110_1101, 8,  2};
      vecs[1]  = '{8'hFF,        8,  7};
      vecs[2]  = '{8'hAA,        8,  0};
      vecs[3]  = '{8'hFF,        0,  0};
      vecs[4]  = '{8'hFF,        15, 7};
      vecs[5]  = '{8'h80,        8,  0};
      vecs[6]  = '{8'h01,        8,  0};
      vecs[7]  = '{8'h07,        3,  2};
      vecs[8]  = '{8'h07,        2,  1};
      vecs[9]  = '{8'hFF,        1,  0};
      vecs[10] = '{8'hF0,        8,  3};
      vecs[11] = '{8'h5B,        9,  2};

      bus.start = 1'b0;
      bus.pat   = '0;
      bus.len   = '0;
      rst_b     = 1'b0;
      #12;
      check_output("reset x", 32'(bus.x), 32'd0);
      check_output("reset x_valid", 32'(bus.x_valid), 32'd0);
      check_output("reset busy", 32'(bus.busy), 32'd0);
      check_output("reset done", 32'(bus.done), 32'd0);
      check_output("reset exp_cnt", 32'(bus.exp_cnt), 32'd0);
      @(negedge clk);
      rst_b = 1'b1;

      // Reset mid-frame: three 1s out, then abort asynchronously.
      @(negedge clk);
      bus.start = 1'b1;
      bus.pat   = 8'hFF;
      bus.len   = 4'd8;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check_output("abort pre x", 32'(bus.x), 32'd1);
      check_output("abort pre busy", 32'(bus.busy), 32'd1);
      #2 rst_b = 1'b0;
      #1;
      check_output("abort x", 32'(bus.x), 32'd0);
      check_output("abort x_valid", 32'(bus.x_valid), 32'd0);
      check_output("abort busy", 32'(bus.busy), 32'd0);
      check_output("abort exp_cnt", 32'(bus.exp_cnt), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check_output("abort no done", 32'(bus.done), 32'd0);
         check_output("abort no busy", 32'(bus.busy), 32'd0);
      end
      apply_stimulus(8'hFF, 8, 7, 1'b0, "post-abort");

      for (int v = 0; v < 12; v++)
         apply_stimulus(vecs[v].pat, vecs[v].len, vecs[v].exp_cnt, 1'b0, $sformatf("vec%0d", v));

      // Start held high: pattern changes after acceptance, two gap cycles between frames.
      @(negedge clk);
      cur_p     = 8'b0110_1101;
      cur_l     = 8;
      bus.start = 1'b1;
      bus.pat   = cur_p;
      bus.len   = LEN_W'(cur_l);
      for (int f = 0; f < 4; f++) begin
         @(posedge clk); #1;
         nxt_p   = WIDTH'($urandom);
         nxt_l   = $urandom_range(1, 8);
         bus.pat = nxt_p;
         bus.len = LEN_W'(nxt_l);
         if (f == 3) bus.start = 1'b0;
         check_frame_body(cur_p, cur_l, model_pairs(cur_p, cur_l), 1'b0, $sformatf("b2b%0d", f));
         @(posedge clk); #1;
         check_output("b2b gap x_valid", 32'(bus.x_valid), 32'd0);
         check_output("b2b gap done", 32'(bus.done), 32'd0);
         cur_p = nxt_p;
         cur_l = nxt_l;
      end

      // Random frames with start toggled while busy; it must be ignored.
      for (int r = 0; r < 30; r++) begin
         rp = WIDTH'($urandom);
         rl = $urandom_range(0, 15);
         apply_stimulus(rp, rl, model_pairs(rp, rl), 1'b1, $sformatf("rnd%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/seq11_pattern_tx.md
Name: seq11_pattern_tx

Overview:
Serial pattern transmitter that drives the single-bit stream `x` consumed by the "11" sequence detector. A frame is a parallel pattern of up to WIDTH bits, which is shifted out one bit per clock, LSB first. While transmitting, the block also counts the overlapping "11" occurrences it sends. `exp_cnt` is therefore the golden count of detector `y` pulses for that frame. The block sits on the stimulus side of the detector in the same clock domain and serves as both a test-pattern source and a scoreboard reference.

Parameters:
WIDTH, 8, maximum frame length in bits (pattern register width); legal range 2..32.
LEN_W, 4, width of `len` port; must be >= clog2(WIDTH+1).
CNT_W, 3, width of `exp_cnt`; must be >= clog2(WIDTH).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_b  input  1  asynchronous active-low reset.
start  input  1  frame request, sampled only in IDLE.
pat  input  WIDTH  pattern to send; bit 0 is transmitted first.
len  input  LEN_W  number of bits to send; values > WIDTH are clamped to WIDTH.
x  output  1  serial data bit to the detector.
x_valid  output  1  high when `x` carries a frame bit.
busy  output  1  high while in SHIFT.
done  output  1  single-cycle pulse after the last bit.
exp_cnt  output  CNT_W  number of overlapping "11" pairs sent in the current/last frame.

Behaviour:
- Reset (async, rst_b=0): state=IDLE; x=0, x_valid=0, busy=0, done=0, exp_cnt=0; shift register, bit counter and prev-bit flag cleared. Asserting reset mid-frame aborts the frame immediately; no done pulse is generated.
- All outputs are registered. x and x_valid change only on the clk edge.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - x=0, x_valid=0, busy=0, done=0.
  - On a clock edge with start=1, latch pat and eff_len=min(len,WIDTH), clear exp_cnt and prev.
  - If eff_len=0, go to DONE. Otherwise go to SHIFT.
- SHIFT:
  - One bit per cycle: x=shift[0], x_valid=1, busy=1.
  - First bit appears in the cycle after start is sampled, i.e. 1-cycle latency.
  - After eff_len bits, go to DONE.
  - Each bit cycle with x=1 and prev=1 increments exp_cnt (saturating at 2^CNT_W-1); prev then takes x.
- DONE (exactly one cycle):
  - done=1, x=0, x_valid=0, busy=0; next state is IDLE.
  - This guarantees at least one x=0 gap cycle between frames, so the detector sits in S0 at every frame start and counts never span frames.
- start is ignored in SHIFT and DONE (no queuing). start held high in IDLE launches back-to-back frames separated by DONE+IDLE (2 gap cycles).
- pat/len changes after acceptance have no effect on the frame in flight.
- exp_cnt holds its value from done until the next accepted start.
- Overlap rule: "111" counts 2, matching a Mealy detector that stays in S1 on repeated 1s.
- Frame length in cycles = eff_len SHIFT cycles + 1 DONE cycle.

Test Plan:
1. Reset mid-frame: start with pat=8'hFF, len=8; assert rst_b=0 after 3 bits -> x=0, x_valid=0, busy=0, exp_cnt=0 asynchronously; no done pulse follows; next start behaves normally.
2. pat=8'b0110_1101, len=8 -> x sequence 1,0,1,1,0,1,1,0 on consecutive cycles starting 1 cycle after start; done pulses on cycle 9; exp_cnt=2; detector y pulses 2 times, aligned with bits 4 and 7.
3. pat=8'hFF, len=8 -> eight 1s, exp_cnt=7, detector y=1 for 7 cycles; pat=8'hAA, len=8 -> exp_cnt=0, y never asserted.
4. len=0 -> no x_valid cycle, done pulses 1 cycle after start, exp_cnt=0; len=15 (> WIDTH) -> exactly 8 bits sent.
5. start held high with pat changing mid-frame -> frame bits match the pattern latched at acceptance; each subsequent frame starts exactly 2 cycles after the prior last bit; start pulses during SHIFT/DONE are ignored.
6. Frame ending in 1 (pat=8'h80, len=8) followed by frame starting with 1 (pat=8'h01) -> exp_cnt=0 for both frames and no detector y across the boundary.
